// File: rtl/stack_arbiter.sv
// Round-robin arbiter that shares one LIFO stack between clients A and B.
// Each grant becomes a single Push/Pop strobe, rejected up front when the stack flags forbid it.
module stack_arbiter #(
    parameter int DW    = 4,
    parameter int DEPTH = 8,
    parameter int LW    = 4
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Req_A,
    input  logic          Op_A,
    input  logic [DW-1:0] Wdata_A,
    output logic          Done_A,
    output logic          Err_A,
    output logic [DW-1:0] Rdata_A,
    input  logic          Req_B,
    input  logic          Op_B,
    input  logic [DW-1:0] Wdata_B,
    output logic          Done_B,
    output logic          Err_B,
    output logic [DW-1:0] Rdata_B,
    output logic          St_Push,
    output logic          St_Pop,
    output logic [DW-1:0] St_Data_In,
    input  logic [DW-1:0] St_Data_Out,
    input  logic          St_Full,
    input  logic          St_Empty,
    output logic [LW-1:0] Level
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RESP
    } state_t;

    localparam logic CLIENT_A = 1'b0;
    localparam logic CLIENT_B = 1'b1;

    state_t          state_q, state_d;
    logic            winner_q, winner_d;
    logic            op_q, op_d;
    logic [DW-1:0]   data_q, data_d;
    logic            last_q, last_d;
    logic [LW-1:0]   level_q, level_d;

    logic            done;
    logic            err;
    logic            illegal;
    logic            win;
    logic [DW-1:0]   rdata;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            winner_q <= CLIENT_A;
            op_q     <= 1'b0;
            data_q   <= '0;
            last_q   <= CLIENT_B;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            op_q     <= op_d;
            data_q   <= data_d;
            last_q   <= last_d;
            level_q  <= level_d;
        end
    end

    // A pop is illegal on an empty stack, a push on a full one.
    assign illegal = op_q ? St_Empty : St_Full;

    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        op_d       = op_q;
        data_d     = data_q;
        last_d     = last_q;
        level_d    = level_q;
        done       = 1'b0;
        err        = 1'b0;
        rdata      = '0;
        win        = CLIENT_A;
        St_Push    = 1'b0;
        St_Pop     = 1'b0;
        St_Data_In = '0;

        case (state_q)
            IDLE: begin
                if (Req_A || Req_B) begin
                    if (Req_A && Req_B) begin
                        win = ~last_q;
                    end else begin
                        win = Req_B ? CLIENT_B : CLIENT_A;
                    end
                    winner_d = win;
                    op_d     = (win == CLIENT_B) ? Op_B : Op_A;
                    data_d   = (win == CLIENT_B) ? Wdata_B : Wdata_A;
                    last_d   = win;
                    state_d  = CMD;
                end
            end
            CMD: begin
                if (illegal) begin
                    done    = 1'b1;
                    err     = 1'b1;
                    state_d = IDLE;
                end else begin
                    if (op_q) begin
                        St_Pop = 1'b1;
                        if (level_q != '0) begin
                            level_d = level_q - LW'(1);
                        end
                    end else begin
                        St_Push    = 1'b1;
                        St_Data_In = data_q;
                        if (level_q != LW'(DEPTH)) begin
                            level_d = level_q + LW'(1);
                        end
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                done    = 1'b1;
                rdata   = op_q ? St_Data_Out : '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Done_A  = done && (winner_q == CLIENT_A);
    assign Err_A   = err  && (winner_q == CLIENT_A);
    assign Rdata_A = (winner_q == CLIENT_A) ? rdata : '0;
    assign Done_B  = done && (winner_q == CLIENT_B);
    assign Err_B   = err  && (winner_q == CLIENT_B);
    assign Rdata_B = (winner_q == CLIENT_B) ? rdata : '0;
    assign Level   = level_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed testbench for stack_arbiter with a small behavioural 8-deep LIFO attached.
module tb_stack_arbiter;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Req_A = 1'b0, Op_A = 1'b0;
    logic [3:0] Wdata_A = '0;
    logic       Req_B = 1'b0, Op_B = 1'b0;
    logic [3:0] Wdata_B = '0;
    logic       Done_A, Err_A, Done_B, Err_B;
    logic [3:0] Rdata_A, Rdata_B;
    logic       St_Push, St_Pop;
    logic [3:0] St_Data_In;
    logic [3:0] St_Data_Out;
    logic       St_Full, St_Empty;
    logic [3:0] Level;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    stack_arbiter #(.DW(4), .DEPTH(8), .LW(4)) dut (
        .Clk(Clk), .Rst(Rst),
        .Req_A(Req_A), .Op_A(Op_A), .Wdata_A(Wdata_A),
        .Done_A(Done_A), .Err_A(Err_A), .Rdata_A(Rdata_A),
        .Req_B(Req_B), .Op_B(Op_B), .Wdata_B(Wdata_B),
        .Done_B(Done_B), .Err_B(Err_B), .Rdata_B(Rdata_B),
        .St_Push(St_Push), .St_Pop(St_Pop), .St_Data_In(St_Data_In),
        .St_Data_Out(St_Data_Out), .St_Full(St_Full), .St_Empty(St_Empty),
        .Level(Level)
    );

    // Behavioural stack sharing the arbiter's reset; read data is registered on pop.
    logic [3:0] mem [8];
    int         cnt;
    always @(posedge Clk) begin
        if (Rst) begin
            cnt         <= 0;
            St_Data_Out <= '0;
        end else if (St_Push && cnt < 8) begin
            mem[cnt] <= St_Data_In;
            cnt      <= cnt + 1;
        end else if (St_Pop && cnt > 0) begin
            St_Data_Out <= mem[cnt-1];
            cnt         <= cnt - 1;
        end
    end
    assign St_Full  = (cnt == 8);
    assign St_Empty = (cnt == 0);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic resetDut();
        Rst = 1'b1;
        Req_A = 1'b0;
        Req_B = 1'b0;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
    endtask

    // One transaction from client cl (0=A, 1=B); checks latency, strobes, Err and Rdata.
    task automatic applyStimulus(input bit cl, input bit op, input logic [3:0] wd,
                                 input bit expErr, input logic [3:0] expRd, input int expLat);
        int  n;
        bit  done;
        @(negedge Clk);
        if (cl) begin Req_B = 1'b1; Op_B = op; Wdata_B = wd; end
        else    begin Req_A = 1'b1; Op_A = op; Wdata_A = wd; end
        n = 0;
        done = 0;
        while (!done && n < 10) begin
            @(negedge Clk);
            n++;
            if (n == 1) begin
                checkOutput("push_strobe", 32'(St_Push), 32'(!expErr && !op));
                checkOutput("pop_strobe", 32'(St_Pop), 32'(!expErr && op));
                if (!expErr && !op) checkOutput("st_data_in", 32'(St_Data_In), 32'(wd));
            end
            done = cl ? Done_B : Done_A;
        end
        checkOutput("latency", 32'(n), 32'(expLat));
        checkOutput("other_done", 32'(cl ? Done_A : Done_B), 32'(0));
        checkOutput("err", 32'(cl ? Err_B : Err_A), 32'(expErr));
        checkOutput("rdata", 32'(cl ? Rdata_B : Rdata_A), 32'(expRd));
        Req_A = 1'b0;
        Req_B = 1'b0;
    endtask

    initial begin
        int  grants;
        int  overlap;
        bit  gotA;
        bit  gotB;

        resetDut();
        checkOutput("rst_done_a", 32'(Done_A), 32'(0));
        checkOutput("rst_done_b", 32'(Done_B), 32'(0));
        checkOutput("rst_push", 32'(St_Push), 32'(0));
        checkOutput("rst_pop", 32'(St_Pop), 32'(0));
        checkOutput("rst_level", 32'(Level), 32'(0));

        applyStimulus(1'b0, 1'b0, 4'h3, 1'b0, 4'h0, 2);
        checkOutput("level_after_push3", 32'(Level), 32'(1));

        applyStimulus(1'b0, 1'b0, 4'h5, 1'b0, 4'h0, 2);
        checkOutput("level_after_push5", 32'(Level), 32'(2));
        applyStimulus(1'b1, 1'b1, 4'h0, 1'b0, 4'h5, 2);
        checkOutput("level_after_pop", 32'(Level), 32'(1));
        repeat (2) @(negedge Clk);
        checkOutput("idle_push", 32'(St_Push), 32'(0));
        checkOutput("idle_pop", 32'(St_Pop), 32'(0));

        // Both clients held: grants must alternate A, B, A, B.
        resetDut();
        Req_A = 1'b1; Op_A = 1'b0; Wdata_A = 4'hA;
        Req_B = 1'b1; Op_B = 1'b0; Wdata_B = 4'hB;
        grants = 0;
        overlap = 0;
        for (int c = 0; c < 40 && grants < 4; c++) begin
            @(negedge Clk);
            if (Done_A && Done_B) overlap++;
            if (Done_A || Done_B) begin
                checkOutput("alt_order", 32'(Done_B), 32'(grants % 2));
                grants++;
                checkOutput("alt_level", 32'(Level), 32'(grants));
                if (grants == 4) begin
                    Req_A = 1'b0;
                    Req_B = 1'b0;
                end
            end
        end
        checkOutput("alt_grants", 32'(grants), 32'(4));
        checkOutput("alt_overlap", 32'(overlap), 32'(0));

        // Fill to capacity, reject a 9th push, drain, reject a 9th pop.
        resetDut();
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 4'(i), 1'b0, 4'h0, 2);
        checkOutput("full_level", 32'(Level), 32'(8));
        applyStimulus(1'b0, 1'b0, 4'hF, 1'b1, 4'h0, 1);
        checkOutput("full_level_kept", 32'(Level), 32'(8));
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 4'h0, 1'b0, 4'(7 - i), 2);
        checkOutput("empty_level", 32'(Level), 32'(0));
        applyStimulus(1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 1);
        checkOutput("empty_level_kept", 32'(Level), 32'(0));

        // Reset while a pop sits in CMD.
        applyStimulus(1'b0, 1'b0, 4'h6, 1'b0, 4'h0, 2);
        @(negedge Clk);
        Req_A = 1'b1; Op_A = 1'b1;
        @(negedge Clk);
        checkOutput("abort_pop_strobe", 32'(St_Pop), 32'(1));
        Rst = 1'b1;
        Req_A = 1'b0;
        @(negedge Clk);
        checkOutput("abort_done_a", 32'(Done_A), 32'(0));
        checkOutput("abort_level", 32'(Level), 32'(0));
        Rst = 1'b0;
        Req_A = 1'b1; Op_A = 1'b0; Wdata_A = 4'h1;
        Req_B = 1'b1; Op_B = 1'b0; Wdata_B = 4'h2;
        gotA = 0;
        gotB = 0;
        for (int c = 0; c < 20 && !(gotA && gotB); c++) begin
            @(negedge Clk);
            if ((Done_A || Done_B) && !gotA && !gotB) begin
                checkOutput("post_rst_first_a", 32'(Done_A), 32'(1));
                checkOutput("post_rst_first_b", 32'(Done_B), 32'(0));
            end
            if (Done_A) begin gotA = 1; Req_A = 1'b0; end
            if (Done_B) begin gotB = 1; Req_B = 1'b0; end
        end
        checkOutput("post_rst_both_done", 32'(gotA && gotB), 32'(1));
        checkOutput("post_rst_level", 32'(Level), 32'(2));

        // Operands changed after latch must not reach the stack.
        @(negedge Clk);
        Req_A = 1'b1; Op_A = 1'b0; Wdata_A = 4'h9;
        @(negedge Clk);
        Op_A = 1'b1;
        Wdata_A = 4'h2;
        #1;
        checkOutput("latched_push", 32'(St_Push), 32'(1));
        checkOutput("latched_no_pop", 32'(St_Pop), 32'(0));
        checkOutput("latched_data", 32'(St_Data_In), 32'(9));
        @(negedge Clk);
        checkOutput("latched_done", 32'(Done_A), 32'(1));
        Req_A = 1'b0;
        applyStimulus(1'b1, 1'b1, 4'h0, 1'b0, 4'h9, 2);
        checkOutput("final_level", 32'(Level), 32'(2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
- Shares one 4-bit LIFO stack instance between two requesters, A and B.
- Runs round-robin arbitration over the two clients.
- Sequences each granted operation as a single-cycle Push or Pop strobe to the stack and returns the pop data and a completion status to the winning client.
- Checks the stack's Full/Empty flags before issuing, so illegal operations are rejected with an error instead of being silently dropped.

Parameters:
- DW, 4, data width of client data and stack data.
- DEPTH, 8, stack capacity; sizes the occupancy counter.
- LW, 4, width of Level; must satisfy 2^LW > DEPTH.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  synchronous active-high reset.
- Req_A  input  1  client A request; held until Done_A.
- Op_A  input  1  client A operation: 0 = push, 1 = pop.
- Wdata_A  input  DW  client A push data.
- Done_A  output  1  one-cycle completion pulse to A.
- Err_A  output  1  valid with Done_A; 1 = rejected (push while full, or pop while empty).
- Rdata_A  output  DW  pop result; valid only when Done_A=1, Err_A=0 and the op was a pop; 0 otherwise.
- Req_B, Op_B, Wdata_B, Done_B, Err_B, Rdata_B: same as the A ports, for client B.
- St_Push  output  1  push strobe to stack.
- St_Pop  output  1  pop strobe to stack.
- St_Data_In  output  DW  data to stack.
- St_Data_Out  input  DW  stack read data; registered in the stack, updated at the edge ending a pop.
- St_Full  input  1  stack full flag.
- St_Empty  input  1  stack empty flag.
- Level  output  LW  tracked occupancy, 0..DEPTH.

Behaviour:
- Reset (Rst=1 at a rising edge):
  - State goes to IDLE; Level=0; Last=B, so A has priority first.
  - All outputs read 0.
  - Reset mid-operation aborts without Done. The integration ties the stack's reset to the same event so Level stays consistent.
- FSM states: IDLE, CMD, RESP.
- IDLE:
  - If Req_A or Req_B is set, select a winner.
  - Only one requesting: that one wins. Both requesting: the client not equal to Last wins.
  - Latch winner id, Op and Wdata; set Last=winner; go to CMD. No requests: stay in IDLE.
- CMD:
  - Illegal op (push with St_Full=1, or pop with St_Empty=1): no strobe; assert Done_x=1 and Err_x=1 this cycle; next state IDLE.
  - Legal op: assert St_Push or St_Pop for exactly this cycle; St_Data_In = latched data on a push, 0 otherwise; next state RESP.
  - Level +1 on a legal push, -1 on a legal pop, at the edge ending CMD.
- RESP:
  - Done_x=1, Err_x=0.
  - On a pop, Rdata_x = St_Data_Out.
  - Next state IDLE.
- Latency, Req sampled in IDLE to Done: 2 cycles for a legal op, 1 cycle for a rejected op. Peak throughput is one legal op per 3 cycles.
- Outputs:
  - Done/Err/strobes are Moore decodes of state plus the latched winner/op, with the flag check applied in CMD.
  - Never more than one of St_Push/St_Pop high; never both Done_A and Done_B high.
- Client rule: the client deasserts Req in the cycle after Done. A Req still high in IDLE is treated as a new request.
- Requester inputs are ignored outside IDLE. Operands changing after latch have no effect.
- Flags are sampled in CMD, i.e. after the previous op's edge, so back-to-back ops always see updated Full/Empty.
- Level saturates logically: a legal op never drives it below 0 or above DEPTH.

Test Plan:
- Reset then A pushes 4'h3 → St_Push pulses 1 cycle with St_Data_In=3; Done_A with Err_A=0 two cycles after request; Level=1.
- A pushes 5, then B pops → Done_B with Rdata_B=5, Err_B=0; Level returns to its prior value; no strobes in IDLE.
- Both Req_A and Req_B held continuously with pushes after reset → grants alternate A, B, A, B; Done pulses never overlap; Level increments each transaction.
- 8 pushes of 0..7, then a 9th push → 9th gets Done+Err 1 cycle after request, no St_Push; Level=8. Next 8 pops return 7..0; a 9th pop → Err, no St_Pop, Rdata=0.
- Rst asserted during CMD of a pop → no Done; next cycle is IDLE with Level=0; the first request after reset from both clients is granted to A.
- Op_A and Wdata_A changed during CMD → stack receives the originally latched values.
